mod_addsub_pipe: RTL and testbench



---
 rtl/mod_addsub_pipe.sv | 112 +++++++++++
 tb/tb_mod_addsub_pipe.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mod_addsub_pipe
// Brief    : Two-stage multi-lane modular adder/subtractor, z = (x +/- y) mod MOD,
//            valid/ready on both sides. Optional MOD_RANGE_CHECK_EN adds out_err_o.
// Revision : 1.0 - initial release
// ============================================================================
module mod_addsub_pipe #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned MOD    = 3329,
    parameter int unsigned LANES  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic                    in_op_i,
    input  logic [LANES*DATA_W-1:0] in_x_i,
    input  logic [LANES*DATA_W-1:0] in_y_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [LANES*DATA_W-1:0] out_z_o
`ifdef MOD_RANGE_CHECK_EN
    ,
    output logic                    out_err_o
`endif
);

    localparam logic [DATA_W:0]   C_MOD_W = (DATA_W+1)'(MOD);
    localparam logic [DATA_W-1:0] C_MOD_N = DATA_W'(MOD);

    logic                         s1_valid_q, s1_valid_d;
    logic                         s1_op_q;
    logic [LANES-1:0][DATA_W:0]   s1_raw_q, s1_raw_d;
    logic                         s2_valid_q, s2_valid_d;
    logic [LANES-1:0][DATA_W-1:0] s2_z_q, s2_z_d;
    logic                         w_s2_adv;

    // S2 can take new data when it is empty or its content leaves this cycle
    assign w_s2_adv   = !s2_valid_q | out_ready_i;
    assign in_ready_o = !s1_valid_q | w_s2_adv;

    assign s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
    assign s2_valid_d = w_s2_adv   ? s1_valid_q : s2_valid_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DATA_W:0] w_x, w_y, w_r;
        assign w_x = {1'b0, in_x_i[i*DATA_W +: DATA_W]};
        assign w_y = {1'b0, in_y_i[i*DATA_W +: DATA_W]};
        assign w_r = s1_raw_q[i];
        // Bit DATA_W of the raw value is the borrow for subtract
        assign s1_raw_d[i] = in_op_i ? (w_x - w_y) : (w_x + w_y);
        assign s2_z_d[i]   = s1_op_q
                           ? (w_r[DATA_W] ? (w_r[DATA_W-1:0] + C_MOD_N) : w_r[DATA_W-1:0])
                           : ((w_r >= C_MOD_W) ? DATA_W'(w_r - C_MOD_W) : w_r[DATA_W-1:0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 1'b0;
            s1_raw_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_z_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            if (in_ready_o) begin
                s1_op_q  <= in_op_i;
                s1_raw_q <= s1_raw_d;
            end
            if (w_s2_adv) begin
                s2_z_q <= s2_z_d;
            end
        end
    end

    assign out_valid_o = s2_valid_q;
    assign out_z_o     = s2_z_q;

`ifdef MOD_RANGE_CHECK_EN
    logic [LANES-1:0] w_oor;
    logic             s1_err_q, s1_err_d;
    logic             s2_err_q, s2_err_d;

    for (genvar i = 0; i < LANES; i++) begin : g_range
        assign w_oor[i] = (in_x_i[i*DATA_W +: DATA_W] >= C_MOD_N)
                        | (in_y_i[i*DATA_W +: DATA_W] >= C_MOD_N);
    end

    assign s1_err_d = |w_oor;
    assign s2_err_d = s1_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_err_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            if (in_ready_o) begin
                s1_err_q <= s1_err_d;
            end
            if (w_s2_adv) begin
                s2_err_q <= s2_err_d;
            end
        end
    end

    assign out_err_o = s2_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_addsub_pipe
// Brief    : Self-checking bench for mod_addsub_pipe (queue model + directed vectors).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_addsub_pipe;

    localparam int DATA_W = 14;
    localparam int MOD    = 3329;
    localparam int LANES  = 2;
    localparam int W      = LANES * DATA_W;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_op     = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] in_x      = '0;
    logic [W-1:0] in_y      = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_z;
`ifdef MOD_RANGE_CHECK_EN
    logic         out_err;
`endif

    int n_pass  = 0;
    int n_total = 0;

    logic [W-1:0] exp_q[$];
    bit           err_q[$];
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_z     = '0;

    always #5 clk = ~clk;

    mod_addsub_pipe #(
        .DATA_W (DATA_W),
        .MOD    (MOD),
        .LANES  (LANES)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_op_i     (in_op),
        .in_x_i      (in_x),
        .in_y_i      (in_y),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_z_o     (out_z)
`ifdef MOD_RANGE_CHECK_EN
        ,
        .out_err_o   (out_err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic [W-1:0] lanes(input int a0, input int a1);
        return {DATA_W'(a1), DATA_W'(a0)};
    endfunction

    // Reference: plain integer modular arithmetic per lane
    function automatic logic [W-1:0] model_z(input logic op, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
        logic [W-1:0] z;
        int a, b;
        z = '0;
        for (int l = 0; l < LANES; l++) begin
            a = int'(x[l*DATA_W +: DATA_W]);
            b = int'(y[l*DATA_W +: DATA_W]);
            z[l*DATA_W +: DATA_W] = DATA_W'(op ? ((a - b + MOD) % MOD) : ((a + b) % MOD));
        end
        return z;
    endfunction

    function automatic bit model_err(input logic [W-1:0] x, input logic [W-1:0] y);
        bit e;
        e = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (int'(x[l*DATA_W +: DATA_W]) >= MOD || int'(y[l*DATA_W +: DATA_W]) >= MOD)
                e = 1'b1;
        end
        return e;
    endfunction

    // Compare process: scoreboard of accepted transactions, checked on every output transfer
    always @(negedge clk) begin
        logic [W-1:0] z;
        bit           e;
        if (!rst_n) begin
            exp_q.delete();
            err_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_z_held", out_z, prev_z);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 0);
                end else begin
                    z = exp_q.pop_front();
                    e = err_q.pop_front();
                    if (!e) check("stream_z", out_z, z);
`ifdef MOD_RANGE_CHECK_EN
                    check("stream_err", out_err, e);
`endif
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model_z(in_op, in_x, in_y));
                err_q.push_back(model_err(in_x, in_y));
            end
            prev_stall = out_valid && !out_ready;
            prev_z     = out_z;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the acceptance edge
    task automatic send(input logic op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_op = op; in_x = x; in_y = y; in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t >= 20) begin
                check("send_timeout", in_ready, 1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Hand-computed expectation for a lone transaction just sent into an empty pipe
    task automatic expect_lit(input string name, input int z0, input int z1, input bit err);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 8);
        check({name, "_latency"}, n, 2);
        check({name, "_z"}, out_z, lanes(z0, z1));
`ifdef MOD_RANGE_CHECK_EN
        check({name, "_err"}, out_err, err);
`else
        if (err) $display("note: %s expects err but range check is disabled", name);
`endif
        @(posedge clk); #1;
    endtask

    initial begin
        int acc, idx;
        bit a;
        logic [W-1:0] sx[6], sy[6];

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_z", out_z, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed vectors
        send(1'b1, lanes(5, 10), lanes(10, 5));
        expect_lit("t1_sub", 3324, 5, 1'b0);
        send(1'b0, lanes(3000, 3328), lanes(500, 3328));
        expect_lit("t2_add_wrap", 171, 3327, 1'b0);
        send(1'b0, lanes(1664, 0), lanes(1665, 0));
        expect_lit("t2_add_eq_mod", 0, 0, 1'b0);
        send(1'b1, lanes(7, 3328), lanes(7, 0));
        expect_lit("t2_sub_equal", 0, 3328, 1'b0);
        send(1'b1, lanes(0, 1), lanes(3328, 3328));
        expect_lit("t2_sub_borrow", 1, 2, 1'b0);

        // Back-to-back random stream
        for (int i = 0; i < 100; i++) begin
            in_op    = 1'($urandom_range(0, 1));
            in_x     = lanes($urandom_range(0, MOD-1), $urandom_range(0, MOD-1));
            in_y     = lanes($urandom_range(0, MOD-1), $urandom_range(0, MOD-1));
            in_valid = 1'b1;
            @(negedge clk);
            check("t3_in_ready", in_ready, 1);
            if (i >= 2) check("t3_out_valid", out_valid, 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        check("t3_drained", exp_q.size(), 0);

        // Backpressure: stream offered while downstream stalls
        for (int k = 0; k < 6; k++) begin
            sx[k] = lanes(100 * k + 11, 3000 - k);
            sy[k] = lanes(50 * k + 3, 400 + 7 * k);
        end
        out_ready = 1'b0;
        acc = 0; idx = 0;
        in_op = 1'b0; in_x = sx[0]; in_y = sy[0]; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            a = in_ready;
            if (a) acc++;
            @(posedge clk); #1;
            if (a) begin
                idx++;
                in_op = 1'(idx % 2); in_x = sx[idx]; in_y = sy[idx];
            end
        end
        @(negedge clk);
        check("t4_accepted", acc, 2);
        check("t4_in_ready_low", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && idx < 6; t++) begin
            @(negedge clk);
            a = in_ready;
            @(posedge clk); #1;
            if (a) begin
                idx++;
                if (idx < 6) begin
                    in_op = 1'(idx % 2); in_x = sx[idx]; in_y = sy[idx];
                end
            end
        end
        in_valid = 1'b0;
        check("t4_all_sent", idx, 6);
        repeat (4) @(posedge clk); #1;
        check("t4_drained", exp_q.size(), 0);

        // Reset with two transactions in flight
        in_op = 1'b0; in_x = lanes(1, 2); in_y = lanes(3, 4); in_valid = 1'b1;
        @(posedge clk); #1;
        in_op = 1'b1; in_x = lanes(9, 8); in_y = lanes(7, 6);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t5_async_out_valid", out_valid, 0);
        check("t5_async_out_z", out_z, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("t5_in_ready", in_ready, 1);
        for (int c = 0; c < 4; c++) begin
            check("t5_no_stale", out_valid, 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        send(1'b0, lanes(2000, 1), lanes(2000, 2));
        expect_lit("t5_after_reset", 671, 3, 1'b0);

`ifdef MOD_RANGE_CHECK_EN
        send(1'b0, lanes(1, 3329), lanes(2, 0));
        expect_lit("t6_oor", 3, 0, 1'b1);
        send(1'b0, lanes(1, 3328), lanes(2, 0));
        expect_lit("t6_legal", 3, 3328, 1'b0);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
